// File: rtl/qpi_mem_arbiter.sv
// Two-port arbiter sharing one QPI memory port; one grant per do_read/do_write burst,
// round-robin between ports, grant held until the requester drops and memory goes idle.
module qpi_mem_arbiter #(
    parameter int AW = 25,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_do_read,
    input  logic          p0_do_write,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_next_word,
    output logic          p0_is_idle,
    input  logic          p1_do_read,
    input  logic          p1_do_write,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_next_word,
    output logic          p1_is_idle,
    output logic          m_do_read,
    output logic          m_do_write,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_next_word,
    input  logic          m_is_idle
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state;
    logic   gnt;
    logic   prio;

    logic req0;
    logic req1;
    logic gnt_req;
    logic winner;
    logic busy;
    logic active;

    assign req0    = p0_do_read | p0_do_write;
    assign req1    = p1_do_read | p1_do_write;
    assign gnt_req = gnt ? req1 : req0;
    assign winner  = (req0 & req1) ? prio : req1;
    assign busy    = (state == ST_BUSY);
    assign active  = (state == ST_BUSY) || (state == ST_DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            gnt   <= 1'b0;
            prio  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 | req1) begin
                        gnt   <= winner;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!gnt_req)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Hand priority to the other port only once the adapter has finished
                    if (m_is_idle) begin
                        state <= ST_IDLE;
                        prio  <= ~gnt;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request strobes are gated combinationally so a dropped request leaves the adapter at once
    assign m_do_read  = busy & (gnt ? p1_do_read  : p0_do_read);
    assign m_do_write = busy & (gnt ? p1_do_write : p0_do_write);
    assign m_addr     = active ? (gnt ? p1_addr  : p0_addr)  : '0;
    assign m_wdata    = active ? (gnt ? p1_wdata : p0_wdata) : '0;

    assign p0_rdata     = m_rdata;
    assign p1_rdata     = m_rdata;
    assign p0_next_word = active & ~gnt & m_next_word;
    assign p1_next_word = active &  gnt & m_next_word;

    assign p0_is_idle = ~req0 & ~((state != ST_IDLE) & ~gnt);
    assign p1_is_idle = ~req1 & ~((state != ST_IDLE) &  gnt);

endmodule

// File: tb/tb_qpi_mem_arbiter.sv
// Bench for qpi_mem_arbiter: directed bursts with a scoreboard of delivered read words.
module tb_qpi_mem_arbiter;

    localparam int AW = 25;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_do_read, p0_do_write, p1_do_read, p1_do_write;
    logic [AW-1:0] p0_addr, p1_addr, m_addr;
    logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, m_wdata, m_rdata;
    logic          p0_next_word, p1_next_word, p0_is_idle, p1_is_idle;
    logic          m_do_read, m_do_write, m_next_word, m_is_idle;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } word_t;

    word_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;

    qpi_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_do_read(p0_do_read), .p0_do_write(p0_do_write), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_next_word(p0_next_word),
        .p0_is_idle(p0_is_idle),
        .p1_do_read(p1_do_read), .p1_do_write(p1_do_write), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_next_word(p1_next_word),
        .p1_is_idle(p1_is_idle),
        .m_do_read(m_do_read), .m_do_write(m_do_write), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_next_word(m_next_word),
        .m_is_idle(m_is_idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One adapter word strobe; the expected receiver is queued as it is driven
    task automatic strobe(input bit port, input logic [31:0] d);
        word_t w;
        tick();
        m_next_word = 1'b1;
        m_rdata     = d;
        w.port = port;
        w.data = d;
        sb.push_back(w);
        tick();
        m_next_word = 1'b0;
    endtask

    task automatic finish_burst(input bit port);
        tick();
        if (port) begin p1_do_read = 1'b0; p1_do_write = 1'b0; end
        else      begin p0_do_read = 1'b0; p0_do_write = 1'b0; end
        m_is_idle = 1'b1;
        @(negedge clk);
        chk("fin_do_drop", {62'd0, m_do_read, m_do_write}, 64'd0);
        tick();
        @(negedge clk);
        chk("fin_drain_idle", port ? p1_is_idle : p0_is_idle, 64'd0);
        tick();
        @(negedge clk);
        chk("fin_idle", port ? p1_is_idle : p0_is_idle, 64'd1);
    endtask

    // Output side of the scoreboard: every delivered strobe must match the next queued word
    always @(negedge clk) begin
        if (rst_n && (p0_next_word || p1_next_word)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", {62'd0, p1_next_word, p0_next_word}, 64'd0);
            end else begin
                word_t w;
                w = sb.pop_front();
                chk("sb_port", {62'd0, p1_next_word, p0_next_word},
                    w.port ? 64'd2 : 64'd1);
                chk("sb_data", w.port ? p1_rdata : p0_rdata, {32'd0, w.data});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        p0_do_read = 0; p0_do_write = 0; p0_addr = '0; p0_wdata = '0;
        p1_do_read = 0; p1_do_write = 0; p1_addr = '0; p1_wdata = '0;
        m_rdata = '0; m_next_word = 0; m_is_idle = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_do", {62'd0, m_do_read, m_do_write}, 64'd0);
        chk("rst_m_addr", m_addr, 64'd0);
        chk("rst_m_wdata", m_wdata, 64'd0);
        chk("rst_idle", {62'd0, p1_is_idle, p0_is_idle}, 64'd3);
        chk("rst_nw", {62'd0, p1_next_word, p0_next_word}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Simultaneous reads after reset: p0 first, then p1, then p0 again
        tick();
        p0_do_read = 1; p0_addr = 25'h000100;
        p1_do_read = 1; p1_addr = 25'h000200;
        @(negedge clk);
        chk("t2_no_early", m_do_read, 64'd0);
        tick();
        @(negedge clk);
        chk("t2_g0_rd", m_do_read, 64'd1);
        chk("t2_g0_addr", m_addr, 64'h100);
        chk("t2_p1_wait", p1_is_idle, 64'd0);
        strobe(0, 32'hA0000001);
        strobe(0, 32'hA0000002);
        finish_burst(0);
        tick();
        @(negedge clk);
        chk("t2_g1_rd", m_do_read, 64'd1);
        chk("t2_g1_addr", m_addr, 64'h200);
        strobe(1, 32'hB0000001);
        finish_burst(1);
        tick();
        p0_do_read = 1; p1_do_read = 1;
        tick();
        @(negedge clk);
        chk("t2_rep_addr", m_addr, 64'h100);
        finish_burst(0);
        tick();
        @(negedge clk);
        chk("t2_rep_p1", m_addr, 64'h200);
        finish_burst(1);

        // Single p0 read burst of four words
        tick();
        p0_do_read = 1; p0_addr = 25'h000100;
        tick();
        @(negedge clk);
        chk("t1_rd", m_do_read, 64'd1);
        chk("t1_addr", m_addr, 64'h100);
        for (int i = 0; i < 4; i++) strobe(0, 32'hC0DE0000 + i);
        finish_burst(0);

        // p1 write burst with data advanced on each word strobe
        tick();
        p1_do_write = 1; p1_addr = 25'h000300; p1_wdata = 32'hDEADBEEF;
        tick();
        @(negedge clk);
        chk("t3_wr", {62'd0, m_do_read, m_do_write}, 64'd1);
        chk("t3_wdata0", m_wdata, 64'hDEADBEEF);
        chk("t3_p0_idle", p0_is_idle, 64'd1);
        strobe(1, 32'h0);
        p1_wdata = 32'h12345678;
        @(negedge clk);
        chk("t3_wdata1", m_wdata, 64'h12345678);
        chk("t3_wr_hold", m_do_write, 64'd1);
        chk("t3_p0_idle2", p0_is_idle, 64'd1);
        strobe(1, 32'h1);
        finish_burst(1);

        // Long drain with p1 waiting
        tick();
        p0_do_read = 1; p0_addr = 25'h000400;
        tick();
        p1_do_read = 1; p1_addr = 25'h000500;
        @(negedge clk);
        chk("t4_addr", m_addr, 64'h400);
        chk("t4_p1_wait", p1_is_idle, 64'd0);
        tick();
        p0_do_read = 0; m_is_idle = 0;
        @(negedge clk);
        chk("t4_drop", m_do_read, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("t4_drain_rd", m_do_read, 64'd0);
            chk("t4_drain_idle", {62'd0, p1_is_idle, p0_is_idle}, 64'd0);
        end
        tick();
        m_is_idle = 1;
        @(negedge clk);
        chk("t4_rise", m_do_read, 64'd0);
        tick();
        @(negedge clk);
        chk("t4_idle_gap", m_do_read, 64'd0);
        tick();
        @(negedge clk);
        chk("t4_g1_rd", m_do_read, 64'd1);
        chk("t4_g1_addr", m_addr, 64'h500);
        finish_burst(1);

        // Request dropped on the first granted cycle
        tick();
        p0_do_read = 1; p0_addr = 25'h000600;
        tick();
        p0_do_read = 0;
        @(negedge clk);
        chk("t5_no_pulse", m_do_read, 64'd0);
        chk("t5_p0_busy", p0_is_idle, 64'd0);
        tick();
        tick();
        @(negedge clk);
        chk("t5_back_idle", p0_is_idle, 64'd1);
        chk("t5_m_addr0", m_addr, 64'd0);

        // Asynchronous reset in the middle of a p1 burst
        tick();
        p1_do_read = 1; p1_addr = 25'h000700;
        tick();
        @(negedge clk);
        chk("t6_g1", m_do_read, 64'd1);
        strobe(1, 32'hE0000001);
        strobe(1, 32'hE0000002);
        tick();
        m_next_word = 1; m_rdata = 32'hE0000003;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_rd", m_do_read, 64'd0);
        chk("t6_async_nw", {62'd0, p1_next_word, p0_next_word}, 64'd0);
        @(negedge clk);
        chk("t6_rst_addr", m_addr, 64'd0);
        tick();
        m_next_word = 0;
        p0_do_read = 1; p0_addr = 25'h000800;
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("t6_prio0_rd", m_do_read, 64'd1);
        chk("t6_prio0_addr", m_addr, 64'h800);
        finish_burst(0);
        p1_do_read = 0;

        repeat (3) tick();
        chk("sb_left", sb.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
